// File: rtl/eq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// eq_ctrl_pkg
// Shared definitions for the equalizer gain control front end.
//   HDR            : frame header byte that opens every command frame
//   CMD_SET_BAND   : set one band gain (ARG0 = band, ARG1 = gain)
//   CMD_SET_ALL    : set every band gain to ARG1
//   CMD_SET_EN     : ARG1[0] = equalizer enable, ARG1[1] = amplifier enable
//   parse_state_t  : byte parser state encoding
// -----------------------------------------------------------------------------
package eq_ctrl_pkg;

    localparam logic [7:0] HDR          = 8'hA5;

    localparam logic [7:0] CMD_SET_BAND = 8'h01;
    localparam logic [7:0] CMD_SET_ALL  = 8'h02;
    localparam logic [7:0] CMD_SET_EN   = 8'h03;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_ARG0 = 3'd2,
        ST_ARG1 = 3'd3,
        ST_CHK  = 3'd4,
        ST_EXEC = 3'd5
    } parse_state_t;

endpackage

// File: rtl/eq_gain_bank.sv
// -----------------------------------------------------------------------------
// eq_gain_bank
// Shadow/live register bank for the per-band gains and the two enables.
// Writes land in the shadow copy and set a pending flag; the live copy is
// refreshed from the shadow only on a commit strobe while pending is set.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   commit            : audio sample strobe, commit point
//   wr_band           : write gain to the band selected by band_idx
//   wr_all            : write gain to every band
//   wr_en             : write enables from en_bits ([0]=eq, [1]=amplifier)
//   band_idx          : band to write (already range-checked by the caller)
//   gain              : gain value to write
//   en_bits           : enable values to write
//   amplifier_gains   : packed live gains, band k at [k*GAIN_BITS +: GAIN_BITS]
//   amplifier_enable  : live amplifier enable
//   eq_enable         : live equalizer enable
// -----------------------------------------------------------------------------
module eq_gain_bank #(
    parameter int NUMBER_OF_FILTERS = 10,
    parameter int GAIN_BITS         = 4,
    parameter int DEFAULT_GAIN      = 1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   commit,
    input  logic                                   wr_band,
    input  logic                                   wr_all,
    input  logic                                   wr_en,
    input  logic [7:0]                             band_idx,
    input  logic [GAIN_BITS-1:0]                   gain,
    input  logic [1:0]                             en_bits,
    output logic [NUMBER_OF_FILTERS*GAIN_BITS-1:0] amplifier_gains,
    output logic                                   amplifier_enable,
    output logic                                   eq_enable
);

    localparam logic [GAIN_BITS-1:0] DEF_GAIN = GAIN_BITS'(DEFAULT_GAIN);

    logic [GAIN_BITS-1:0] shadow_gain [NUMBER_OF_FILTERS];
    logic [GAIN_BITS-1:0] live_gain   [NUMBER_OF_FILTERS];
    logic                 shadow_eq_en;
    logic                 shadow_amp_en;
    logic                 pending;
    logic                 do_commit;
    logic                 any_write;

    assign do_commit = commit & pending;
    assign any_write = wr_band | wr_all | wr_en;

    // Shadow side: command writes accumulate here until the next commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUMBER_OF_FILTERS; k++) begin
                shadow_gain[k] <= DEF_GAIN;
            end
            shadow_eq_en  <= 1'b0;
            shadow_amp_en <= 1'b0;
        end else begin
            for (int k = 0; k < NUMBER_OF_FILTERS; k++) begin
                if (wr_all || (wr_band && (band_idx == 8'(k)))) begin
                    shadow_gain[k] <= gain;
                end
            end
            if (wr_en) begin
                shadow_eq_en  <= en_bits[0];
                shadow_amp_en <= en_bits[1];
            end
        end
    end

    // Pending tracks uncommitted shadow changes. A write in the same cycle
    // as a commit keeps it set: the commit took the older shadow contents,
    // so the fresh write still has to go out on a later strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= 1'b0;
        end else if (any_write) begin
            pending <= 1'b1;
        end else if (do_commit) begin
            pending <= 1'b0;
        end
    end

    // Live side: only ever changes on a sample strobe, so the datapath
    // never sees a gain change in the middle of a sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUMBER_OF_FILTERS; k++) begin
                live_gain[k] <= DEF_GAIN;
            end
            eq_enable        <= 1'b0;
            amplifier_enable <= 1'b0;
        end else if (do_commit) begin
            for (int k = 0; k < NUMBER_OF_FILTERS; k++) begin
                live_gain[k] <= shadow_gain[k];
            end
            eq_enable        <= shadow_eq_en;
            amplifier_enable <= shadow_amp_en;
        end
    end

    // Flatten the live gains into the packed bus the equalizer expects.
    always_comb begin
        amplifier_gains = '0;
        for (int k = 0; k < NUMBER_OF_FILTERS; k++) begin
            amplifier_gains[k*GAIN_BITS +: GAIN_BITS] = live_gain[k];
        end
    end

endmodule

// File: rtl/eq_gain_ctrl.sv
// -----------------------------------------------------------------------------
// eq_gain_ctrl
// Command parser for the equalizer gain bank. Parses 5-byte frames
// (A5, CMD, ARG0, ARG1, CHK with CHK = CMD^ARG0^ARG1) from a byte stream,
// validates them and drives the shadow/live gain bank.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   sample_strobe     : one pulse per audio sample, commit point for updates
//   in_data/in_valid  : incoming byte and its valid flag
//   in_ready          : low only during the one-cycle execute state
//   amplifier_gains   : packed live band gains
//   amplifier_enable  : live amplifier enable
//   eq_enable         : live equalizer enable
//   frame_ok          : one-cycle pulse when a frame is executed
//   frame_err         : one-cycle pulse when a frame is rejected or times out
// -----------------------------------------------------------------------------
module eq_gain_ctrl
    import eq_ctrl_pkg::*;
#(
    parameter int NUMBER_OF_FILTERS = 10,
    parameter int GAIN_BITS         = 4,
    parameter int DEFAULT_GAIN      = 1,
    parameter int TIMEOUT_CYCLES    = 1_000_000
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   sample_strobe,
    input  logic [7:0]                             in_data,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    output logic [NUMBER_OF_FILTERS*GAIN_BITS-1:0] amplifier_gains,
    output logic                                   amplifier_enable,
    output logic                                   eq_enable,
    output logic                                   frame_ok,
    output logic                                   frame_err
);

    // Gap counter only needs to hold 0 .. TIMEOUT_CYCLES-1.
    localparam int GAP_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYCLES - 1);

    parse_state_t     state;
    logic [7:0]       cmd_q;
    logic [7:0]       arg0_q;
    logic [7:0]       arg1_q;
    logic [7:0]       chk_acc;
    logic [GAP_W-1:0] gap_cnt;
    logic             exec_valid;

    logic             accept;
    logic             band_ok;
    logic             gain_ok;
    logic             frame_valid;
    logic             exec_go;
    logic             wr_band;
    logic             wr_all;
    logic             wr_en;

    assign accept = in_valid & in_ready;

    // Frame validation, evaluated while the CHK byte is on in_data so the
    // verdict is ready to register on the same edge that accepts it.
    always_comb begin
        band_ok     = ({24'd0, arg0_q} < 32'(NUMBER_OF_FILTERS));
        gain_ok     = ((32'(arg1_q) >> GAIN_BITS) == 32'd0);
        frame_valid = 1'b0;
        if (in_data == chk_acc) begin
            case (cmd_q)
                CMD_SET_BAND: frame_valid = band_ok & gain_ok;
                CMD_SET_ALL:  frame_valid = gain_ok;
                CMD_SET_EN:   frame_valid = 1'b1;
                default:      frame_valid = 1'b0;
            endcase
        end
    end

    // Parser FSM with registered handshake and status pulses. Mid-frame
    // states share the gap counter: any accepted byte clears it, and a full
    // TIMEOUT_CYCLES without one abandons the frame with an error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            cmd_q      <= '0;
            arg0_q     <= '0;
            arg1_q     <= '0;
            chk_acc    <= '0;
            gap_cnt    <= '0;
            exec_valid <= 1'b0;
            in_ready   <= 1'b1;
            frame_ok   <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    gap_cnt <= '0;
                    if (accept && (in_data == HDR)) begin
                        state <= ST_CMD;
                    end
                end
                ST_CMD, ST_ARG0, ST_ARG1, ST_CHK: begin
                    if (accept) begin
                        gap_cnt <= '0;
                        case (state)
                            ST_CMD: begin
                                cmd_q   <= in_data;
                                chk_acc <= in_data;
                                state   <= ST_ARG0;
                            end
                            ST_ARG0: begin
                                arg0_q  <= in_data;
                                chk_acc <= chk_acc ^ in_data;
                                state   <= ST_ARG1;
                            end
                            ST_ARG1: begin
                                arg1_q  <= in_data;
                                chk_acc <= chk_acc ^ in_data;
                                state   <= ST_CHK;
                            end
                            default: begin
                                exec_valid <= frame_valid;
                                frame_ok   <= frame_valid;
                                frame_err  <= ~frame_valid;
                                in_ready   <= 1'b0;
                                state      <= ST_EXEC;
                            end
                        endcase
                    end else if (gap_cnt == GAP_LAST) begin
                        gap_cnt   <= '0;
                        frame_err <= 1'b1;
                        state     <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                ST_EXEC: begin
                    exec_valid <= 1'b0;
                    in_ready   <= 1'b1;
                    state      <= ST_IDLE;
                end
                default: begin
                    exec_valid <= 1'b0;
                    in_ready   <= 1'b1;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

    // Bank write strobes are only live during the execute cycle of a frame
    // that passed validation.
    assign exec_go = (state == ST_EXEC) && exec_valid;
    assign wr_band = exec_go && (cmd_q == CMD_SET_BAND);
    assign wr_all  = exec_go && (cmd_q == CMD_SET_ALL);
    assign wr_en   = exec_go && (cmd_q == CMD_SET_EN);

    eq_gain_bank #(
        .NUMBER_OF_FILTERS (NUMBER_OF_FILTERS),
        .GAIN_BITS         (GAIN_BITS),
        .DEFAULT_GAIN      (DEFAULT_GAIN)
    ) u_bank (
        .clk              (clk),
        .rst              (rst),
        .commit           (sample_strobe),
        .wr_band          (wr_band),
        .wr_all           (wr_all),
        .wr_en            (wr_en),
        .band_idx         (arg0_q),
        .gain             (GAIN_BITS'(arg1_q)),
        .en_bits          (arg1_q[1:0]),
        .amplifier_gains  (amplifier_gains),
        .amplifier_enable (amplifier_enable),
        .eq_enable        (eq_enable)
    );

endmodule

// File: tb/tb_eq_gain_ctrl.sv
// -----------------------------------------------------------------------------
// tb_eq_gain_ctrl
// Directed bench for eq_gain_ctrl: frames, rejects, commits on the sample
// strobe, strobe coincident with execute, inter-byte timeout, mid-frame reset.
// -----------------------------------------------------------------------------
module tb_eq_gain_ctrl;

    localparam int NF  = 10;
    localparam int GB  = 4;
    localparam int TMO = 32;

    logic          clk;
    logic          rst;
    logic          sample_strobe;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic [NF*GB-1:0] amplifier_gains;
    logic          amplifier_enable;
    logic          eq_enable;
    logic          frame_ok;
    logic          frame_err;

    int checks = 0;
    int errors = 0;

    eq_gain_ctrl #(
        .NUMBER_OF_FILTERS (NF),
        .GAIN_BITS         (GB),
        .DEFAULT_GAIN      (1),
        .TIMEOUT_CYCLES    (TMO)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .sample_strobe    (sample_strobe),
        .in_data          (in_data),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .amplifier_gains  (amplifier_gains),
        .amplifier_enable (amplifier_enable),
        .eq_enable        (eq_enable),
        .frame_ok         (frame_ok),
        .frame_err        (frame_err)
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something wedges the sequence.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One byte, presented for exactly one clock; leaves us #1 after the edge.
    task automatic applyStimulus(input logic [7:0] b);
        in_data  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_strobe();
        sample_strobe = 1'b1;
        @(posedge clk);
        #1;
        sample_strobe = 1'b0;
    endtask

    // Full frame; checks the status pulses in the execute cycle, optionally
    // raising the sample strobe in that same cycle, then steps past it.
    task automatic send_frame(input string tag, input logic [7:0] b0,
                              input logic [7:0] b1, input logic [7:0] b2,
                              input logic [7:0] b3, input logic [7:0] b4,
                              input logic exp_ok, input logic strobe_in_exec);
        applyStimulus(b0);
        applyStimulus(b1);
        applyStimulus(b2);
        applyStimulus(b3);
        applyStimulus(b4);
        checkOutput({tag, "_ok"},  64'(frame_ok),  64'(exp_ok));
        checkOutput({tag, "_err"}, 64'(frame_err), 64'(!exp_ok));
        checkOutput({tag, "_rdy"}, 64'(in_ready),  64'd0);
        sample_strobe = strobe_in_exec;
        @(posedge clk);
        #1;
        sample_strobe = 1'b0;
        checkOutput({tag, "_pulse_end"}, 64'({frame_ok, frame_err}), 64'd0);
    endtask

    initial begin
        int  seen_at;
        rst           = 1'b1;
        sample_strobe = 1'b0;
        in_data       = 8'h00;
        in_valid      = 1'b0;

        // Reset state.
        idle_cycles(3);
        checkOutput("rst_gains", 64'(amplifier_gains), 64'h1111111111);
        checkOutput("rst_en", 64'({amplifier_enable, eq_enable}), 64'd0);
        checkOutput("rst_rdy", 64'(in_ready), 64'd1);
        checkOutput("rst_pulses", 64'({frame_ok, frame_err}), 64'd0);
        rst = 1'b0;
        idle_cycles(2);

        // Single band write: no live change until the strobe.
        send_frame("band3", 8'hA5, 8'h01, 8'h03, 8'h07, 8'h05, 1'b1, 1'b0);
        idle_cycles(2);
        checkOutput("band3_pre", 64'(amplifier_gains), 64'h1111111111);
        pulse_strobe();
        checkOutput("band3_post", 64'(amplifier_gains), 64'h1111117111);

        // Rejected frames leave everything untouched.
        send_frame("badchk", 8'hA5, 8'h01, 8'h03, 8'h07, 8'h06, 1'b0, 1'b0);
        send_frame("band10", 8'hA5, 8'h01, 8'h0A, 8'h02, 8'h09, 1'b0, 1'b0);
        send_frame("gain16", 8'hA5, 8'h01, 8'h00, 8'h10, 8'h11, 1'b0, 1'b0);
        send_frame("badcmd", 8'hA5, 8'h04, 8'h00, 8'h00, 8'h04, 1'b0, 1'b0);
        pulse_strobe();
        checkOutput("rej_gains", 64'(amplifier_gains), 64'h1111117111);
        checkOutput("rej_en", 64'({amplifier_enable, eq_enable}), 64'd0);

        // Back-to-back frames accumulate, one strobe commits both.
        send_frame("setall9", 8'hA5, 8'h02, 8'h00, 8'h09, 8'h0B, 1'b1, 1'b0);
        send_frame("seten3",  8'hA5, 8'h03, 8'h00, 8'h03, 8'h00, 1'b1, 1'b0);
        checkOutput("acc_pre", 64'(amplifier_gains), 64'h1111117111);
        pulse_strobe();
        checkOutput("acc_gains", 64'(amplifier_gains), 64'h9999999999);
        checkOutput("acc_en", 64'({amplifier_enable, eq_enable}), 64'd3);

        // Strobe coincident with execute commits only the older shadow.
        send_frame("band0_5", 8'hA5, 8'h01, 8'h00, 8'h05, 8'h04, 1'b1, 1'b0);
        send_frame("band1_6", 8'hA5, 8'h01, 8'h01, 8'h06, 8'h06, 1'b1, 1'b1);
        checkOutput("coinc_first", 64'(amplifier_gains), 64'h9999999995);
        pulse_strobe();
        checkOutput("coinc_second", 64'(amplifier_gains), 64'h9999999965);

        // Junk is dropped silently; a stalled frame times out after TMO cycles.
        applyStimulus(8'h00);
        checkOutput("junk00", 64'({frame_ok, frame_err}), 64'd0);
        applyStimulus(8'hFF);
        checkOutput("junkFF", 64'({frame_ok, frame_err}), 64'd0);
        applyStimulus(8'hA5);
        applyStimulus(8'h01);
        seen_at = 0;
        for (int i = 1; i <= TMO + 8; i++) begin
            @(posedge clk);
            #1;
            if (frame_err && seen_at == 0) seen_at = i;
        end
        checkOutput("tmo_cycle", 64'(seen_at), 64'(TMO));
        checkOutput("tmo_after", 64'({frame_ok, frame_err, in_ready}), 64'd1);
        send_frame("post_tmo", 8'hA5, 8'h01, 8'h09, 8'h03, 8'h0B, 1'b1, 1'b0);
        pulse_strobe();
        checkOutput("post_tmo_gains", 64'(amplifier_gains), 64'h3999999965);

        // Gaps just under the limit between every byte must not time out.
        applyStimulus(8'hA5);
        idle_cycles(TMO - 2);
        applyStimulus(8'h02);
        idle_cycles(TMO - 2);
        applyStimulus(8'h00);
        idle_cycles(TMO - 2);
        applyStimulus(8'h04);
        idle_cycles(TMO - 2);
        checkOutput("slow_no_err", 64'(frame_err), 64'd0);
        applyStimulus(8'h06);
        checkOutput("slow_ok", 64'({frame_ok, frame_err}), 64'd2);
        idle_cycles(1);
        pulse_strobe();
        checkOutput("slow_gains", 64'(amplifier_gains), 64'h4444444444);
        checkOutput("slow_en", 64'({amplifier_enable, eq_enable}), 64'd3);

        // Reset in the middle of a frame: immediate defaults, no pulses.
        applyStimulus(8'hA5);
        applyStimulus(8'h01);
        applyStimulus(8'h02);
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_gains", 64'(amplifier_gains), 64'h1111111111);
        checkOutput("mid_rst_en", 64'({amplifier_enable, eq_enable}), 64'd0);
        checkOutput("mid_rst_pulses", 64'({frame_ok, frame_err}), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_cycles(1);
        checkOutput("after_rst_pulses", 64'({frame_ok, frame_err}), 64'd0);
        send_frame("after_rst", 8'hA5, 8'h01, 8'h02, 8'h08, 8'h0B, 1'b1, 1'b0);
        pulse_strobe();
        checkOutput("after_rst_gains", 64'(amplifier_gains), 64'h1111111811);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
